// File: rtl/iot_pkg.sv
// Shared constants and types for the IoT event arbiter and the monitor counter it feeds.
package iot_pkg;

    localparam logic DIR_ON  = 1'b1;
    localparam logic DIR_OFF = 1'b0;

    // Defaults shared with the active-device monitor counter.
    localparam int unsigned DefCntW       = 8;
    localparam int unsigned DefMaxDevices = 200;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_e;

endpackage

// File: rtl/iot_event_arbiter_if.sv
// Gateway-side event bus between the requesting ports and the arbiter.
interface iot_event_arbiter_if
    import iot_pkg::*;
#(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned CNT_W   = DefCntW
);

    logic [N_PORTS-1:0] req;
    logic [N_PORTS-1:0] dir;
    logic               hold;
    logic [N_PORTS-1:0] ack;
    logic [N_PORTS-1:0] nack;
    logic               change;
    logic               on_off;
    logic [CNT_W-1:0]   shadow_count;
    logic               full;
    logic               empty;

    modport master (
        output req, dir, hold,
        input  ack, nack, change, on_off, shadow_count, full, empty
    );

    modport slave (
        input  req, dir, hold,
        output ack, nack, change, on_off, shadow_count, full, empty
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin search: first eligible index after rr_ptr_i, wrapping modulo N_PORTS.
module rr_picker #(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned PtrW    = 2
) (
    input  logic [N_PORTS-1:0] eligible_i,
    input  logic [PtrW-1:0]    rr_ptr_i,
    output logic [PtrW-1:0]    winner_o,
    output logic               valid_o
);

    int unsigned idx;

    always_comb begin
        valid_o  = 1'b0;
        winner_o = rr_ptr_i;
        idx      = 0;
        for (int unsigned off = 1; off <= N_PORTS; off++) begin
            idx = 32'(rr_ptr_i) + off;
            if (idx >= N_PORTS) begin
                idx = idx - N_PORTS;
            end
            if (!valid_o && eligible_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = PtrW'(idx);
            end
        end
    end

endmodule

// File: rtl/iot_event_arbiter.sv
// Round-robin arbiter forwarding connect/disconnect events to the active-device monitor.
// Optional statistics outputs are enabled with the IOT_ARB_STATS_EN macro.
module iot_event_arbiter
    import iot_pkg::*;
#(
    parameter int unsigned N_PORTS     = 4,
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned MAX_DEVICES = DefMaxDevices
) (
    input  logic                          clk,
    input  logic                          rst,
    iot_event_arbiter_if.slave            bus
`ifdef IOT_ARB_STATS_EN
    ,
    output logic [15:0]                   refuse_cnt,
    output logic [$clog2(N_PORTS)-1:0]    last_refused
`endif
);

    localparam int unsigned PtrW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_DEVICES);

    arb_state_e         state_q, state_d;
    logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [N_PORTS-1:0] ack_q, ack_d;
    logic [N_PORTS-1:0] nack_q, nack_d;
    logic               change_q, change_d;
    logic               on_off_q, on_off_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;

    logic [N_PORTS-1:0] eligible;
    logic [PtrW-1:0]    winner;
    logic               win_valid;
    logic               grant;

    // A port whose response is on the bus this cycle is masked from arbitration.
    assign eligible = bus.req & ~((ack_q | nack_q) & {N_PORTS{state_q == StGrant}});
    assign grant    = win_valid && !bus.hold;

    rr_picker #(
        .N_PORTS (N_PORTS),
        .PtrW    (PtrW)
    ) u_rr_picker (
        .eligible_i (eligible),
        .rr_ptr_i   (rr_ptr_q),
        .winner_o   (winner),
        .valid_o    (win_valid)
    );

    always_comb begin
        state_d  = StIdle;
        rr_ptr_d = rr_ptr_q;
        ack_d    = '0;
        nack_d   = '0;
        change_d = 1'b0;
        on_off_d = 1'b0;
        count_d  = count_q;
        if (grant) begin
            state_d  = StGrant;
            rr_ptr_d = winner;
            if (bus.dir[winner] == DIR_ON && count_q < MaxCnt) begin
                ack_d[winner] = 1'b1;
                change_d      = 1'b1;
                on_off_d      = DIR_ON;
                count_d       = count_q + CNT_W'(1);
            end else if (bus.dir[winner] == DIR_OFF && count_q != '0) begin
                ack_d[winner] = 1'b1;
                change_d      = 1'b1;
                on_off_d      = DIR_OFF;
                count_d       = count_q - CNT_W'(1);
            end else begin
                nack_d[winner] = 1'b1;
            end
        end
        full_d  = (count_d == MaxCnt);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= PtrW'(N_PORTS - 1);
            ack_q    <= '0;
            nack_q   <= '0;
            change_q <= 1'b0;
            on_off_q <= 1'b0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            ack_q    <= ack_d;
            nack_q   <= nack_d;
            change_q <= change_d;
            on_off_q <= on_off_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign bus.ack          = ack_q;
    assign bus.nack         = nack_q;
    assign bus.change       = change_q;
    assign bus.on_off       = on_off_q;
    assign bus.shadow_count = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;

`ifdef IOT_ARB_STATS_EN
    logic [15:0]     refuse_cnt_q, refuse_cnt_d;
    logic [PtrW-1:0] last_refused_q, last_refused_d;

    always_comb begin
        refuse_cnt_d   = refuse_cnt_q;
        last_refused_d = last_refused_q;
        if (|nack_d) begin
            last_refused_d = winner;
            if (refuse_cnt_q != 16'hFFFF) begin
                refuse_cnt_d = refuse_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refuse_cnt_q   <= '0;
            last_refused_q <= '0;
        end else begin
            refuse_cnt_q   <= refuse_cnt_d;
            last_refused_q <= last_refused_d;
        end
    end

    assign refuse_cnt   = refuse_cnt_q;
    assign last_refused = last_refused_q[$clog2(N_PORTS)-1:0];
`endif

endmodule

// File: tb/tb_iot_event_arbiter.sv
// Directed self-checking bench for iot_event_arbiter (4 ports, 8-bit count, ceiling 200).
module tb_iot_event_arbiter;
    import iot_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    iot_event_arbiter_if #(.N_PORTS(4), .CNT_W(8)) bus ();

`ifdef IOT_ARB_STATS_EN
    logic [15:0] refuse_cnt;
    logic [1:0]  last_refused;
`endif

    iot_event_arbiter #(
        .N_PORTS     (4),
        .CNT_W       (8),
        .MAX_DEVICES (200)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef IOT_ARB_STATS_EN
        ,
        .refuse_cnt   (refuse_cnt),
        .last_refused (last_refused)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_strobes(input string tag, input logic [3:0] ack, input logic [3:0] nack,
                                 input logic change, input logic on_off, input logic [7:0] cnt);
        check({tag, ".ack"}, 32'(bus.ack), 32'(ack));
        check({tag, ".nack"}, 32'(bus.nack), 32'(nack));
        check({tag, ".change"}, 32'(bus.change), 32'(change));
        if (change) check({tag, ".on_off"}, 32'(bus.on_off), 32'(on_off));
        check({tag, ".count"}, 32'(bus.shadow_count), 32'(cnt));
    endtask

    initial begin
        logic [3:0] exp_ack;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        bus.req  = '0;
        bus.dir  = '0;
        bus.hold = 1'b0;
        step();
        step();
        check_strobes("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0);
        check("reset.on_off", 32'(bus.on_off), 32'd0);
        check("reset.full", 32'(bus.full), 32'd0);
        check("reset.empty", 32'(bus.empty), 32'd1);
        rst = 1'b0;

        // All four ports connect; each drops req after its ack.
        bus.req = 4'b1111;
        bus.dir = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_ack = 4'b0001 << i;
            check_strobes("rr_order", exp_ack, 4'b0000, 1'b1, 1'b1, 8'(i + 1));
            bus.req = bus.req & ~bus.ack;
        end
        step();
        check_strobes("rr_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd4);
        check("rr_idle.empty", 32'(bus.empty), 32'd0);

        // Ports 0/1 alternate to fill up to 200.
        bus.req = 4'b0011;
        bus.dir = 4'b0011;
        for (int i = 0; i < 196; i++) step();
        bus.req = 4'b0000;
        check("fill.count", 32'(bus.shadow_count), 32'd200);
        check("fill.full", 32'(bus.full), 32'd1);
        check("fill.last_ack", 32'(bus.ack), 32'b0010);
        step();

        // Connect at the ceiling is refused; disconnect is then accepted after the mask cycle.
        bus.req = 4'b0100;
        bus.dir = 4'b0100;
        step();
        check_strobes("ceiling", 4'b0000, 4'b0100, 1'b0, 1'b0, 8'd200);
        check("ceiling.full", 32'(bus.full), 32'd1);
        bus.dir = 4'b0000;
        step();
        check_strobes("mask", 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd200);
        step();
        check_strobes("off_at_full", 4'b0100, 4'b0000, 1'b1, 1'b0, 8'd199);
        check("off_at_full.full", 32'(bus.full), 32'd0);
        bus.req = 4'b0000;
        step();

        // Disconnect at zero is refused.
        rst = 1'b1;
        step();
        rst     = 1'b0;
        bus.req = 4'b0010;
        bus.dir = 4'b0000;
        step();
        check_strobes("floor", 4'b0000, 4'b0010, 1'b0, 1'b0, 8'd0);
        check("floor.empty", 32'(bus.empty), 32'd1);
        bus.req = 4'b0000;
        step();

        // Two continuous requesters alternate starting from port 0.
        rst = 1'b1;
        step();
        rst     = 1'b0;
        bus.req = 4'b1001;
        bus.dir = 4'b1001;
        for (int i = 0; i < 6; i++) begin
            step();
            exp_ack = (i % 2 == 0) ? 4'b0001 : 4'b1000;
            check_strobes("alt", exp_ack, 4'b0000, 1'b1, 1'b1, 8'(i + 1));
        end
        bus.req = 4'b0000;
        step();

        // Hold blocks grants; releasing it grants port 1 then port 2.
        bus.hold = 1'b1;
        bus.req  = 4'b0110;
        bus.dir  = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            step();
            check_strobes("hold", 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd6);
        end
        bus.hold = 1'b0;
        step();
        check_strobes("release1", 4'b0010, 4'b0000, 1'b1, 1'b1, 8'd7);
        bus.req = 4'b0100;
        step();
        check_strobes("release2", 4'b0100, 4'b0000, 1'b1, 1'b1, 8'd8);
        bus.req = 4'b0000;
        step();

        // Reset right after a registered grant discards the pending one.
        bus.req = 4'b0011;
        bus.dir = 4'b0011;
        step();
        check_strobes("pre_rst", 4'b0001, 4'b0000, 1'b1, 1'b1, 8'd9);
        rst = 1'b1;
        step();
        check_strobes("mid_rst", 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0);
        check("mid_rst.empty", 32'(bus.empty), 32'd1);
        check("mid_rst.on_off", 32'(bus.on_off), 32'd0);
        bus.req = 4'b0000;
        rst     = 1'b0;
        step();

`ifdef IOT_ARB_STATS_EN
        bus.req = 4'b0111;
        bus.dir = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_ack = 4'b0001 << i;
            check_strobes("refuse", 4'b0000, exp_ack, 1'b0, 1'b0, 8'd0);
            bus.req = bus.req & ~bus.nack;
        end
        check("stats.refuse_cnt", 32'(refuse_cnt), 32'd3);
        check("stats.last_refused", 32'(last_refused), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("stats.rst_cnt", 32'(refuse_cnt), 32'd0);
        check("stats.rst_last", 32'(last_refused), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iot_event_arbiter.md
Name: iot_event_arbiter

Overview:
Shares the single active-device monitor counter between N_PORTS device-gateway requesters.
- Each port raises connect/disconnect events.
- The arbiter grants one event per cycle, round-robin, and drives the monitor's change/on_off strobes.
- It keeps a shadow count that refuses events which would wrap the count past MAX_DEVICES or below 0.
- It sits between the gateway ports and the monitor counter in the IoT status path.

Parameters:
- N_PORTS, 4, number of requesting ports (2..8).
- CNT_W, 8, width of the shadow count; must match the monitor counter width.
- MAX_DEVICES, 200, ceiling for the active-device count; must be < 2**CNT_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_PORTS  per-port event request, level, held until acknowledged.
- dir  input  N_PORTS  per-port direction: 1 = device on (connect), 0 = device off; valid while req is high.
- hold  input  1  when high, no new grants are issued; pending requests stay pending.
- ack  output  N_PORTS  one-cycle pulse: event accepted and forwarded to the monitor.
- nack  output  N_PORTS  one-cycle pulse: event refused (count limit reached).
- change  output  1  monitor strobe: one event this cycle.
- on_off  output  1  monitor direction: 1 = count up, 0 = count down; meaningful only with change.
- shadow_count  output  CNT_W  arbiter's mirror of the monitor count.
- full  output  1  shadow_count == MAX_DEVICES.
- empty  output  1  shadow_count == 0.

Behaviour:
- Reset (rst=1 at a clock edge): ack=0, nack=0, change=0, on_off=0, shadow_count=0, full=0, empty=1, rr pointer=N_PORTS-1.
  - Reset mid-operation discards any in-flight grant; no ack/nack is issued for it.
  - The monitor is reset by the same rst, so both counts stay aligned.
- Eligible set: req[i]=1 AND ack[i]=0 AND nack[i]=0. A port's req is ignored in the cycle its own response is high.
- Requesters must drop req, or present a new event, on the cycle after seeing ack/nack.
- Arbitration:
  - If hold=0 and the eligible set is non-empty, pick the first eligible index searching from rr_ptr+1 upward, modulo N_PORTS.
  - rr_ptr updates to the winner on both accept and refuse.
- Decision for winner w, with the outputs registered on the next edge (latency 1 cycle from a sampled req):
  - dir[w]=1 and shadow_count<MAX_DEVICES: ack[w]=1, change=1, on_off=1, shadow_count+1.
  - dir[w]=0 and shadow_count>0: ack[w]=1, change=1, on_off=0, shadow_count-1.
  - Otherwise: nack[w]=1, change=0, shadow_count unchanged.
- At most one of ack/nack is high per cycle across all ports. change=1 only together with an ack.
- No grant cycle: all strobes 0 and shadow_count holds. This covers hold=1, an empty eligible set, and the post-response mask.
- Throughput: one event per cycle across ports. A single port gets at most one event every 2 cycles because of the mask.
- full/empty are registered and update in the same cycle as shadow_count.
- No wrap-around is possible: arithmetic never exceeds MAX_DEVICES or drops below 0.
- Internal FSM (2 states):
  - IDLE: no grant registered.
  - GRANT: a response is being presented.
  - IDLE -> GRANT on any arbitration win.
  - GRANT -> GRANT on a back-to-back win by another port.
  - GRANT -> IDLE when there is no winner.

Optional Feature:
IOT_ARB_STATS_EN
- Defined:
  - Adds output refuse_cnt [15:0], counting nack pulses; it saturates at 16'hFFFF and is cleared by rst.
  - Adds output last_refused [$clog2(N_PORTS)-1:0], the index of the most recently refused port; reset 0.
- Undefined: neither port exists, no extra logic, and the rest of the behaviour is identical.

Decomposition:
- Package iot_pkg holds:
  - the DIR_ON=1 / DIR_OFF=0 constants;
  - the arbiter state enum (IDLE, GRANT);
  - the default CNT_W and MAX_DEVICES constants shared with the monitor.
- One sub-module, rr_picker: combinational round-robin search (eligible vector + rr_ptr -> winner index + valid).

Test Plan:
- Reset, then req=4'b1111, dir=4'b1111 held, each port dropping req after its ack -> acks in port order 0,1,2,3 on cycles 1..4; shadow_count=4; change high for 4 cycles, on_off=1.
- Preload shadow_count=200 via 200 ons, then port 2 requests on -> nack[2]=1, change=0, count stays 200, full=1; port 2 then requests off -> ack[2], count=199, full=0.
- From reset, port 1 requests off -> nack[1]=1, count 0, empty=1, no change strobe.
- Ports 0 and 3 request continuously (re-asserting after each response) -> grants alternate 0,3,0,3; neither waits more than 1 extra cycle.
- hold=1 with req=4'b0110 for 5 cycles -> no ack/nack/change; hold=0 -> port 1 granted on the next edge, then port 2.
- rst asserted the cycle after a grant was registered -> all outputs return to reset values next edge; no stale ack. With IOT_ARB_STATS_EN, 3 refusals give refuse_cnt=3 before rst and 0 after.
